mlp2_stream_engine: RTL
=======================

// Module: mlp2_stream_engine
// PURPOSE
//  Time-multiplexed two-layer fully-connected inference engine (dense+ReLU -> dense+linear/ReLU), successor to the
//  fully-parallel network top. Input vector streams in one element per beat over valid/ready. HID layer-1 and OUT
//  layer-2 MACs run in parallel; weights are fetched per step from external async-read memories. Result vector plus
//  argmax class are held on a valid/ready output port. Sits between the feature front-end and the classifier sink.
// PARAMETERS
//  W          16   signed fixed-point width of data, weights, biases, hidden and output values
//  FRAC       8    fractional bits (Q(W-FRAC).FRAC) for all values
//  IN_LEN     784  input vector length (beats per inference), >=2
//  HID        10   layer-1 neuron count, >=2
//  OUT        10   layer-2 neuron count, >=2
//  ACC_W      2*W+$clog2(IN_LEN>HID?IN_LEN:HID)+1   accumulator width, no overflow possible internally
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst        in   1            asynchronous active-high reset
//  in_valid   in   1            input element valid
//  in_ready   out  1            engine accepts input element
//  in_data    in   W            input element, signed
//  w1_addr    out  clog2(IN_LEN) layer-1 weight row address (= input element index)
//  w1_rdata   in   HID*W        weights W1[j][w1_addr], neuron j at bits [j*W +: W], same-cycle (async) read
//  b1         in   HID*W        layer-1 biases, quasi-static
//  w2_addr    out  clog2(HID)   layer-2 weight row address (= hidden index)
//  w2_rdata   in   OUT*W        weights W2[i][w2_addr], neuron i at bits [i*W +: W], same-cycle read
//  b2         in   OUT*W        layer-2 biases, quasi-static
//  act2_relu  in   1            1: ReLU on layer 2, 0: linear; sampled on first accepted input beat
//  out_valid  out  1            result held valid
//  out_ready  in   1            sink accepts result
//  out_data   out  OUT*W        layer-2 outputs, neuron i at [i*W +: W]
//  out_class  out  clog2(OUT)   index of maximum out_data entry
//  busy       out  1            high in every state except LOAD with counter 0
// BEHAVIOUR
//  States: LOAD -> ACT1 -> MAC2 -> ACT2 -> OUTP -> LOAD. Reset: LOAD, counters 0, acc1/acc2 0, out_data 0,
//   out_class 0, out_valid 0, act2 mode 0. in_ready = (state==LOAD), combinational from state only.
//  LOAD: w1_addr = beat count k. Each in_valid&&in_ready: acc1[j] += in_data*w1_rdata[j] (full-precision signed),
//   k++. No accept when in_valid low (gaps allowed, state frozen). Beat k==IN_LEN-1 -> ACT1, k<=0.
//  ACT1 (1 cycle): h[j] = sat_W(relu((acc1[j] + (b1[j]<<<FRAC)) >>> FRAC)); acc1 cleared; -> MAC2.
//  MAC2 (HID cycles, m=0..HID-1): w2_addr=m; acc2[i] += h[m]*w2_rdata[i]; m==HID-1 -> ACT2.
//  ACT2 (1 cycle): out_data[i] = sat_W(act((acc2[i] + (b2[i]<<<FRAC)) >>> FRAC)); act=ReLU if sampled mode else
//   identity; out_class = argmax over the final saturated values, ties -> lowest index; acc2 cleared; -> OUTP.
//  OUTP: out_valid=1, out_data/out_class stable until out_valid&&out_ready; then out_valid=0, -> LOAD same edge.
//  Latency: out_valid rises exactly HID+2 cycles after the edge accepting the last input beat.
//  Throughput: next vector accepted from the cycle after the output handshake; no overlap.
//  Arithmetic: >>> is arithmetic shift (floor toward -inf); sat_W clamps to [-2^(W-1), 2^(W-1)-1]. Bias and product
//   sign-extended to ACC_W before add.
//  w1_addr holds 0 and w2_addr holds 0 outside LOAD/MAC2 respectively.
//  rst asserted any time (mid-LOAD, MAC2, OUTP): immediate return to reset values; partial vector discarded;
//   out_valid drops asynchronously. act2_relu changes after first beat have no effect on current vector.
// TESTING (W=16, FRAC=8, IN_LEN=4, HID=3, OUT=2 unless noted)
//  1 in=4x256, W1 all 256, b1=0, W2 all 128, b2=0, act2=0 -> out_data={1536,1536}, out_class=0, out_valid exactly
//    5 cycles after last input beat.
//  2 as 1 but b1 all -2048 (-8.0) -> h=0, out_data=b2; b2={-512,300}, act2=0 -> {-512,300}, class 1; act2=1 -> {0,300}.
//  3 in=4x0x7F00, W1 all 0x7F00 -> h saturate 0x7FFF; W1 all 0x8100 -> h clamps via ReLU to 0; check no wrap.
//  4 random in_valid gaps (50%) and out_ready low 10 cycles in OUTP -> in_ready 0, outputs stable, result bit-exact
//    vs reference model; second vector back-to-back after handshake correct (accumulators cleared).
//  5 rst pulse mid-LOAD (after 2 beats) and mid-MAC2 -> next cycle in_ready=1, out_valid=0, busy=0; following full
//    vector gives result identical to test 1.
//  6 default params, 200 random vectors vs golden model incl. tie cases -> out_data and lowest-index out_class exact.

Source files
------------

// File: rtl/mlp2_stream_engine_if.sv
// Stream-side bundle of the two-layer inference engine: element input channel,
// layer-2 activation select and the held result channel.
interface mlp2_stream_engine_if #(
  parameter int W   = 16,
  parameter int OUT = 10
);
  localparam int CW = $clog2(OUT);

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 act2_relu;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT*W-1:0]     out_data;
  logic [CW-1:0]        out_class;

  modport master (
    output in_valid, in_data, act2_relu, out_ready,
    input  in_ready, out_valid, out_data, out_class
  );

  modport slave (
    input  in_valid, in_data, act2_relu, out_ready,
    output in_ready, out_valid, out_data, out_class
  );
endinterface

// File: rtl/mlp2_stream_engine.sv
// Time-multiplexed dense+ReLU -> dense(+optional ReLU) inference engine with
// streamed input, per-step external weight fetch and a held argmax result.
module mlp2_stream_engine #(
  parameter int W      = 16,
  parameter int FRAC   = 8,
  parameter int IN_LEN = 784,
  parameter int HID    = 10,
  parameter int OUT    = 10,
  parameter int ACC_W  = 2*W + $clog2((IN_LEN > HID) ? IN_LEN : HID) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  mlp2_stream_engine_if.slave         strm,
  output logic [$clog2(IN_LEN)-1:0]   w1_addr,
  input  logic [HID*W-1:0]            w1_rdata,
  input  logic [HID*W-1:0]            b1,
  output logic [$clog2(HID)-1:0]      w2_addr,
  input  logic [OUT*W-1:0]            w2_rdata,
  input  logic [OUT*W-1:0]            b2,
  output logic                        busy
);

  localparam int AW1 = $clog2(IN_LEN);
  localparam int AW2 = $clog2(HID);
  localparam int CW  = $clog2(OUT);

  localparam logic [2:0] S_LOAD = 3'd0;
  localparam logic [2:0] S_ACT1 = 3'd1;
  localparam logic [2:0] S_MAC2 = 3'd2;
  localparam logic [2:0] S_ACT2 = 3'd3;
  localparam logic [2:0] S_OUTP = 3'd4;

  localparam logic [AW1-1:0] K_ZERO = AW1'(0);
  localparam logic [AW1-1:0] K_ONE  = AW1'(1);
  localparam logic [AW1-1:0] K_LAST = AW1'(IN_LEN - 1);
  localparam logic [AW2-1:0] M_ZERO = AW2'(0);
  localparam logic [AW2-1:0] M_ONE  = AW2'(1);
  localparam logic [AW2-1:0] M_LAST = AW2'(HID - 1);

  function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = $signed({{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}});
    lo = $signed({{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}});
    if (x > hi) begin
      return hi[W-1:0];
    end else if (x < lo) begin
      return lo[W-1:0];
    end else begin
      return x[W-1:0];
    end
  endfunction

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
    if (x[ACC_W-1]) begin
      return {ACC_W{1'b0}};
    end else begin
      return x;
    end
  endfunction

  // Bias is aligned to the product scale (2*FRAC fraction bits) before the add.
  function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [W-1:0] b);
    logic signed [ACC_W-1:0] t;
    t = {{(ACC_W-W){b[W-1]}}, b};
    return t <<< FRAC;
  endfunction

  function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [W-1:0] a,
                                                      input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = a * b;
    return {{(ACC_W-2*W){p[2*W-1]}}, p};
  endfunction

  logic [2:0]               state_q, state_d;
  logic [AW1-1:0]           k_q, k_d;
  logic [AW2-1:0]           m_q, m_d;
  logic                     mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc1_q [HID];
  logic signed [ACC_W-1:0]  acc1_d [HID];
  logic signed [ACC_W-1:0]  acc2_q [OUT];
  logic signed [ACC_W-1:0]  acc2_d [OUT];
  logic signed [W-1:0]      h_q [HID];
  logic signed [W-1:0]      h_d [HID];
  logic [OUT*W-1:0]         out_data_q, out_data_d;
  logic [CW-1:0]            out_class_q, out_class_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]  prod1_s [HID];
  logic signed [ACC_W-1:0]  prod2_s [OUT];
  logic signed [W-1:0]      h_new_s [HID];
  logic signed [W-1:0]      o_new_s [OUT];
  logic signed [ACC_W-1:0]  o_sh_s;
  logic signed [W-1:0]      best_s;
  logic [CW-1:0]            cls_s;

  // Layer-1 products and the hidden activations formed from the finished sums.
  always_comb begin
    for (int j = 0; j < HID; j++) begin
      prod1_s[j] = mul_ext(strm.in_data, w1_rdata[j*W +: W]);
      h_new_s[j] = sat_w(relu((acc1_q[j] + bias_ext(b1[j*W +: W])) >>> FRAC));
    end
  end

  // Layer-2 products for hidden step m, output activations and argmax (ties keep lowest index).
  always_comb begin
    o_sh_s = {ACC_W{1'b0}};
    for (int i = 0; i < OUT; i++) begin
      prod2_s[i] = mul_ext(h_q[m_q], w2_rdata[i*W +: W]);
      o_sh_s     = (acc2_q[i] + bias_ext(b2[i*W +: W])) >>> FRAC;
      o_new_s[i] = sat_w(mode_q ? relu(o_sh_s) : o_sh_s);
    end
    best_s = o_new_s[0];
    cls_s  = {CW{1'b0}};
    for (int i = 1; i < OUT; i++) begin
      if (o_new_s[i] > best_s) begin
        best_s = o_new_s[i];
        cls_s  = CW'(i);
      end else begin
        best_s = best_s;
      end
    end
  end

  // Sequencer: LOAD -> ACT1 -> MAC2 -> ACT2 -> OUTP -> LOAD.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    m_d         = m_q;
    mode_d      = mode_q;
    acc1_d      = acc1_q;
    acc2_d      = acc2_q;
    h_d         = h_q;
    out_data_d  = out_data_q;
    out_class_d = out_class_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_LOAD: begin
        if (strm.in_valid) begin
          for (int j = 0; j < HID; j++) begin
            acc1_d[j] = acc1_q[j] + prod1_s[j];
          end
          if (k_q == K_ZERO) begin
            mode_d = strm.act2_relu;
          end else begin
            mode_d = mode_q;
          end
          if (k_q == K_LAST) begin
            k_d     = K_ZERO;
            state_d = S_ACT1;
          end else begin
            k_d     = k_q + K_ONE;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_ACT1: begin
        for (int j = 0; j < HID; j++) begin
          h_d[j]    = h_new_s[j];
          acc1_d[j] = {ACC_W{1'b0}};
        end
        m_d     = M_ZERO;
        state_d = S_MAC2;
      end
      S_MAC2: begin
        for (int i = 0; i < OUT; i++) begin
          acc2_d[i] = acc2_q[i] + prod2_s[i];
        end
        if (m_q == M_LAST) begin
          m_d     = M_ZERO;
          state_d = S_ACT2;
        end else begin
          m_d     = m_q + M_ONE;
          state_d = S_MAC2;
        end
      end
      S_ACT2: begin
        for (int i = 0; i < OUT; i++) begin
          out_data_d[i*W +: W] = o_new_s[i];
          acc2_d[i]            = {ACC_W{1'b0}};
        end
        out_class_d = cls_s;
        out_valid_d = 1'b1;
        state_d     = S_OUTP;
      end
      S_OUTP: begin
        if (strm.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_LOAD;
        end else begin
          out_valid_d = 1'b1;
          state_d     = S_OUTP;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        k_d         = K_ZERO;
        m_d         = M_ZERO;
        state_d     = S_LOAD;
      end
    endcase
  end

  // State registers; reset discards any partial vector and drops the result at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      k_q         <= K_ZERO;
      m_q         <= M_ZERO;
      mode_q      <= 1'b0;
      out_data_q  <= {(OUT*W){1'b0}};
      out_class_q <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      for (int j = 0; j < HID; j++) begin
        acc1_q[j] <= {ACC_W{1'b0}};
        h_q[j]    <= {W{1'b0}};
      end
      for (int i = 0; i < OUT; i++) begin
        acc2_q[i] <= {ACC_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      m_q         <= m_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_class_q <= out_class_d;
      out_valid_q <= out_valid_d;
      acc1_q      <= acc1_d;
      h_q         <= h_d;
      acc2_q      <= acc2_d;
    end
  end

  assign strm.in_ready  = (state_q == S_LOAD);
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_class = out_class_q;
  assign w1_addr        = (state_q == S_LOAD) ? k_q : K_ZERO;
  assign w2_addr        = (state_q == S_MAC2) ? m_q : M_ZERO;
  assign busy           = !((state_q == S_LOAD) && (k_q == K_ZERO));

endmodule
